// File: rtl/colorram_access_ctrl_if.sv
// Bus bundle between colorram_access_ctrl and its clients / the color RAM pair.
// slave: controller side; master: environment side (video, CPU decode, RAMs).
interface colorram_access_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              i_PXCEN;
    logic [ADDR_W-1:0] i_PALIDX;
    logic              i_BLANK_n;
    logic [15:0]       o_RGB;
    logic              o_RGB_VLD;
    logic              i_CPU_REQ;
    logic              i_CPU_WR;
    logic              i_CPU_HI;
    logic [ADDR_W-1:0] i_CPU_ADDR;
    logic [7:0]        i_CPU_DIN;
    logic [7:0]        o_CPU_DOUT;
    logic              o_CPU_ACK;
    logic [ADDR_W-1:0] o_RAM_ADDR;
    logic [7:0]        o_RAM_DIN;
    logic              o_RAM_RD_n;
    logic              o_RAM_WR_H_n;
    logic              o_RAM_WR_L_n;
    logic [7:0]        i_RAM_DOUT_H;
    logic [7:0]        i_RAM_DOUT_L;

    modport slave (
        input  i_PXCEN, i_PALIDX, i_BLANK_n,
        input  i_CPU_REQ, i_CPU_WR, i_CPU_HI, i_CPU_ADDR, i_CPU_DIN,
        input  i_RAM_DOUT_H, i_RAM_DOUT_L,
        output o_RGB, o_RGB_VLD, o_CPU_DOUT, o_CPU_ACK,
        output o_RAM_ADDR, o_RAM_DIN, o_RAM_RD_n, o_RAM_WR_H_n, o_RAM_WR_L_n
    );

    modport master (
        output i_PXCEN, i_PALIDX, i_BLANK_n,
        output i_CPU_REQ, i_CPU_WR, i_CPU_HI, i_CPU_ADDR, i_CPU_DIN,
        output i_RAM_DOUT_H, i_RAM_DOUT_L,
        input  o_RGB, o_RGB_VLD, o_CPU_DOUT, o_CPU_ACK,
        input  o_RAM_ADDR, o_RAM_DIN, o_RAM_RD_n, o_RAM_WR_H_n, o_RAM_WR_L_n
    );
endinterface

// File: rtl/colorram_access_ctrl.sv
// Arbitrates video palette reads and CPU byte accesses onto the shared
// high/low color RAM pair; the pixel path always wins.
// state   | meaning
// IDLE    | no access; pending pixel first, then CPU request
// PX_RD   | read strobe at captured palette index
// PX_CAP  | register color word (or blank color)
// CPU_WR  | write strobe to the selected byte RAM
// CPU_RD  | read strobe at CPU address
// CPU_CAP | register CPU read byte
module colorram_access_ctrl #(
    parameter int          ADDR_W      = 11,
    parameter logic [15:0] BLANK_COLOR = 16'h0000
) (
    input logic                   i_MCLK,
    input logic                   i_RST_n,
    colorram_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_PX_RD, S_PX_CAP, S_CPU_WR, S_CPU_RD, S_CPU_CAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
    logic              cap_blank_n_q, cap_blank_n_d;
    logic              pend_q, pend_d;
    logic              px_blank_n_q, px_blank_n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              hi_q, hi_d;
    logic [15:0]       rgb_q, rgb_d;
    logic              rgb_vld_q, rgb_vld_d;
    logic [7:0]        dout_q, dout_d;
    logic              ack_q, ack_d;
    logic              rd_n, wr_h_n, wr_l_n;

    always_ff @(posedge i_MCLK) begin
        if (!i_RST_n) begin
            state_q       <= S_IDLE;
            cap_idx_q     <= '0;
            cap_blank_n_q <= 1'b0;
            pend_q        <= 1'b0;
            px_blank_n_q  <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            hi_q          <= 1'b0;
            rgb_q         <= '0;
            rgb_vld_q     <= 1'b0;
            dout_q        <= '0;
            ack_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_idx_q     <= cap_idx_d;
            cap_blank_n_q <= cap_blank_n_d;
            pend_q        <= pend_d;
            px_blank_n_q  <= px_blank_n_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            hi_q          <= hi_d;
            rgb_q         <= rgb_d;
            rgb_vld_q     <= rgb_vld_d;
            dout_q        <= dout_d;
            ack_q         <= ack_d;
        end
    end

    // A pixel strobe in the same cycle counts as pending so it wins over the CPU.
    // The ack cycle ignores REQ, since the CPU is still holding it from the last access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q || bus.i_PXCEN)
                    state_d = S_PX_RD;
                else if (bus.i_CPU_REQ && !ack_q)
                    state_d = bus.i_CPU_WR ? S_CPU_WR : S_CPU_RD;
            end
            S_PX_RD:   state_d = S_PX_CAP;
            S_PX_CAP:  state_d = S_IDLE;
            S_CPU_WR:  state_d = S_IDLE;
            S_CPU_RD:  state_d = S_CPU_CAP;
            S_CPU_CAP: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cap_idx_d     = bus.i_PXCEN ? bus.i_PALIDX  : cap_idx_q;
        cap_blank_n_d = bus.i_PXCEN ? bus.i_BLANK_n : cap_blank_n_q;
        pend_d        = (state_d == S_PX_RD) ? 1'b0 : (pend_q | bus.i_PXCEN);
        px_blank_n_d  = (state_d == S_PX_RD) ? cap_blank_n_d : px_blank_n_q;
        addr_d        = addr_q;
        din_d         = din_q;
        hi_d          = hi_q;
        rgb_d         = rgb_q;
        rgb_vld_d     = 1'b0;
        dout_d        = dout_q;
        ack_d         = 1'b0;

        if (state_d == S_PX_RD)
            addr_d = cap_idx_d;
        else if ((state_q == S_IDLE) && ((state_d == S_CPU_WR) || (state_d == S_CPU_RD))) begin
            addr_d = bus.i_CPU_ADDR;
            hi_d   = bus.i_CPU_HI;
            if (state_d == S_CPU_WR)
                din_d = bus.i_CPU_DIN;
        end

        case (state_q)
            S_PX_CAP: begin
                rgb_vld_d = 1'b1;
                rgb_d     = px_blank_n_q ? {bus.i_RAM_DOUT_H, bus.i_RAM_DOUT_L} : BLANK_COLOR;
            end
            S_CPU_WR:  ack_d = 1'b1;
            S_CPU_CAP: begin
                ack_d  = 1'b1;
                dout_d = hi_q ? bus.i_RAM_DOUT_H : bus.i_RAM_DOUT_L;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_n   = 1'b1;
        wr_h_n = 1'b1;
        wr_l_n = 1'b1;
        case (state_q)
            S_PX_RD, S_CPU_RD: rd_n = 1'b0;
            S_CPU_WR: begin
                wr_h_n = ~hi_q;
                wr_l_n = hi_q;
            end
            default: ;
        endcase
    end

    assign bus.o_RAM_RD_n   = rd_n;
    assign bus.o_RAM_WR_H_n = wr_h_n;
    assign bus.o_RAM_WR_L_n = wr_l_n;
    assign bus.o_RAM_ADDR   = addr_q;
    assign bus.o_RAM_DIN    = din_q;
    assign bus.o_RGB        = rgb_q;
    assign bus.o_RGB_VLD    = rgb_vld_q;
    assign bus.o_CPU_DOUT   = dout_q;
    assign bus.o_CPU_ACK    = ack_q;

endmodule

// File: doc/colorram_access_ctrl.md
Name: colorram_access_ctrl

Overview:
- Initiator side of the 6116-style color RAM pair (high byte and low byte). Both parts share one address bus and one read strobe, have separate write strobes, and return registered read data one cycle after the read strobe.
- Serves two clients:
  - Video pixel path: palette index in, 16-bit color word out. This path has priority.
  - CPU byte read/write port with a req/ack handshake.
- Sits between the video mixer / CPU bus decode and the two color RAM instances.

Parameters:
ADDR_W, 11, color RAM address width
BLANK_COLOR, 16'h0000, value driven on o_RGB while the sample was taken in blanking

Ports:
i_MCLK  in  1  master clock; all logic on its rising edge
i_RST_n  in  1  synchronous reset, active-low
i_PXCEN  in  1  pixel clock enable; one-cycle pulse, at least 4 i_MCLK apart
i_PALIDX  in  ADDR_W  palette index, sampled when i_PXCEN=1
i_BLANK_n  in  1  0 = blanking, sampled with i_PALIDX
o_RGB  out  16  color word {high byte, low byte}
o_RGB_VLD  out  1  one-cycle pulse when o_RGB updates
i_CPU_REQ  in  1  CPU access request, level
i_CPU_WR  in  1  1 = write, 0 = read
i_CPU_HI  in  1  1 = high-byte RAM, 0 = low-byte RAM
i_CPU_ADDR  in  ADDR_W  CPU address
i_CPU_DIN  in  8  CPU write data
o_CPU_DOUT  out  8  CPU read data, valid with o_CPU_ACK
o_CPU_ACK  out  1  one-cycle completion pulse
o_RAM_ADDR  out  ADDR_W  shared RAM address
o_RAM_DIN  out  8  shared RAM write data
o_RAM_RD_n  out  1  shared read strobe, active-low
o_RAM_WR_H_n  out  1  high-RAM write strobe, active-low
o_RAM_WR_L_n  out  1  low-RAM write strobe, active-low
i_RAM_DOUT_H  in  8  high-RAM registered read data
i_RAM_DOUT_L  in  8  low-RAM registered read data

Behaviour:
- Reset (sampled at an i_MCLK edge with i_RST_n=0):
  - State = IDLE, pixel-pending flag = 0.
  - o_RAM_RD_n=1, o_RAM_WR_H_n=1, o_RAM_WR_L_n=1.
  - o_RAM_ADDR=0, o_RAM_DIN=0, o_RGB=0, o_RGB_VLD=0, o_CPU_DOUT=0, o_CPU_ACK=0.
  - Reset mid-access aborts the access: no ack is issued and strobes are high on the next cycle.
- Pixel capture register:
  - i_PXCEN=1 loads {i_PALIDX, i_BLANK_n} into the capture register and sets the pending flag.
  - i_PXCEN while the flag is already set overwrites the capture register; the older sample is dropped.
- FSM states: IDLE, PX_RD, PX_CAP, CPU_WR, CPU_RD, CPU_CAP.
- IDLE transitions, in priority order:
  - pending=1 -> PX_RD.
  - Else i_CPU_REQ=1 and i_CPU_WR=1 -> CPU_WR.
  - Else i_CPU_REQ=1 and i_CPU_WR=0 -> CPU_RD.
  - Else stay in IDLE.
  - If i_PXCEN and i_CPU_REQ arrive in the same cycle, the pixel path wins.
- PX_RD:
  - Drive o_RAM_ADDR = captured index, o_RAM_RD_n=0.
  - Clear pending.
  - Next state PX_CAP.
- PX_CAP:
  - o_RAM_RD_n=1.
  - At the end of the cycle: o_RGB <= {i_RAM_DOUT_H, i_RAM_DOUT_L} if captured blank_n=1, else BLANK_COLOR; o_RGB_VLD=1 for one cycle.
  - Next state IDLE.
- CPU_WR:
  - Drive o_RAM_ADDR=i_CPU_ADDR, o_RAM_DIN=i_CPU_DIN.
  - Assert o_RAM_WR_H_n=0 if i_CPU_HI=1, else o_RAM_WR_L_n=0.
  - o_CPU_ACK=1 in the following cycle; next state IDLE.
- CPU_RD:
  - o_RAM_ADDR=i_CPU_ADDR, o_RAM_RD_n=0.
  - Latch i_CPU_HI.
  - Next state CPU_CAP.
- CPU_CAP:
  - o_CPU_DOUT <= latched HI ? i_RAM_DOUT_H : i_RAM_DOUT_L.
  - o_CPU_ACK=1 in the following cycle; next state IDLE.
- Write and read strobes are never asserted together; at most one strobe is low in any cycle.
- Latency:
  - i_PXCEN at cycle N with FSM idle -> strobe in N+1, o_RGB and o_RGB_VLD in N+3.
  - With a CPU read in flight, the pixel is deferred: at most N+5.
  - With 4-cycle i_PXCEN spacing, no pixel is ever dropped.
- CPU handshake:
  - CPU holds i_CPU_REQ, address, data, WR and HI stable until o_CPU_ACK.
  - CPU drops i_CPU_REQ in the ack cycle.
  - REQ still high in the cycle after ack starts a new access.
- o_RGB holds its value between updates. o_RAM_ADDR and o_RAM_DIN hold their last values in IDLE.

Test Plan:
1. Reset with i_RST_n=0 for 3 cycles while i_CPU_REQ=1 -> all strobes 1, o_RGB=0000, o_CPU_ACK=0 throughout; first access starts only after release.
2. Preload high[0x123]=A5, low[0x123]=3C; i_PXCEN at N with i_PALIDX=0x123, i_BLANK_n=1 -> o_RAM_RD_n=0 only in N+1; o_RGB=A53C with o_RGB_VLD pulse at N+3.
3. Same as scenario 2 but i_BLANK_n=0 -> o_RGB=0000 at N+3; the RAM read still occurs.
4. CPU write HI=1, addr 0x7FF, data 5A -> o_RAM_WR_H_n low for exactly one cycle, o_RAM_WR_L_n stays 1, ack one cycle later. Then CPU read of 0x7FF -> o_CPU_DOUT=5A with ack.
5. i_PXCEN and i_CPU_REQ (read) in the same cycle -> pixel strobe first, then CPU read strobe; ack 3 cycles after o_RGB_VLD-1 timing; the two strobe cycles never overlap.
6. CPU read issued 1 cycle before i_PXCEN -> pixel deferred; o_RGB_VLD at N+5. Stream of 64 pixels at 4-cycle spacing with continuous CPU writes -> all 64 colors correct, no pixel dropped.
